// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_ctl transmit channel among N_REQ requesters.
// One payload per grant: capture, launch with a data_valid pulse, then wait for tx_done or timeout.
module uart_tx_arb #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    output logic [DATA_W-1:0]         ctl_tx_data,
    output logic                      ctl_data_valid,
    input  logic                      ctl_tx_done,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST =
        (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [ID_W-1:0]  ID_MAX = ID_W'(N_REQ - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [N_REQ-1:0]  err_q, err_d;
    logic              valid_q, valid_d;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   scan_idx;
    logic [DATA_W-1:0] win_data;

    // Scan upward from the requester after the last one served, wrapping at N_REQ-1.
    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves it unassigned (no latch).
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = (last_q == ID_MAX) ? '0 : last_q + ID_W'(1);
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
            scan_idx = (scan_idx == ID_MAX) ? '0 : scan_idx + ID_W'(1);
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) win_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        data_d  = data_q;
        timer_d = timer_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = '0;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    data_d         = win_data;
                    ack_d[win_id]  = 1'b1;
                    grant_d        = win_id;
                    state_d        = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                valid_d = 1'b1;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // tx_done is checked first so it wins over a timeout expiring in the same cycle.
                if (ctl_tx_done) begin
                    done_d[grant_q] = 1'b1;
                    last_d          = grant_q;
                    state_d         = S_IDLE;
                end else if (TIMEOUT_CYCLES != 0 && timer_q == TMR_LAST) begin
                    err_d[grant_q] = 1'b1;
                    last_d         = grant_q;
                    state_d        = S_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= ID_MAX;
            grant_q <= '0;
            // NOTE: the payload register is reset too, because ctl_tx_data is visible and must read 0 after reset.
            data_q  <= '0;
            timer_q <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            timer_q <= timer_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign ack            = ack_q;
    assign done           = done_q;
    assign err            = err_q;
    assign ctl_tx_data    = data_q;
    assign ctl_data_valid = valid_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized transfers
// checked cycle by cycle against a transaction-level round-robin model.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int T  = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      ack, done, err;
    logic [DW-1:0]     ctl_tx_data;
    logic              ctl_data_valid;
    logic              ctl_tx_done;
    logic              busy;
    logic [1:0]        grant_id;

    int                n_cmp = 0;
    int                n_bad = 0;
    int                last_m;
    logic [DW-1:0]     slot [N];

    uart_tx_arb #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .ack            (ack),
        .done           (done),
        .err            (err),
        .ctl_tx_data    (ctl_tx_data),
        .ctl_data_valid (ctl_data_valid),
        .ctl_tx_done    (ctl_tx_done),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first set bit searching upward from last+1 with wrap-around.
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic load_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = slot[i];
    endtask

    // One transfer. dly = cycles after the data_valid cycle at which tx_done is pulsed
    // (>= T means never). exp_w >= 0 additionally pins the expected grant.
    task automatic run_txn(input logic [N-1:0] add, input int dly, input bit reassert, input int exp_w);
        int         w;
        int         n;
        bit         dn;
        logic [N-1:0] oh;
        req = req | add;
        load_data();
        w = pick(req, last_m);
        if (w < 0) begin
            @(negedge clk);
            check("idle_quiet", {ack, busy}, '0);
            return;
        end
        oh = N'(1) << w;
        @(negedge clk);
        check("ack", ack, oh);
        check("gid", grant_id, w);
        check("busy_up", busy, 1);
        check("valid_early", ctl_data_valid, 0);
        if (exp_w >= 0) check("dir_gid", grant_id, exp_w);
        if (!reassert) req[w] = 1'b0;
        @(negedge clk);
        check("valid", ctl_data_valid, 1);
        check("txdata", ctl_tx_data, slot[w]);
        check("ack_pulse", ack, 0);
        dn = (dly < T);
        n  = dn ? dly + 1 : T;
        for (int j = 0; j < n; j++) begin
            ctl_tx_done = (j == dly);
            @(negedge clk);
            ctl_tx_done = 1'b0;
            if (j < n - 1) check("wait_quiet", {ack, done, err, ctl_data_valid, busy}, 14'b1);
        end
        check("done", done, dn ? oh : '0);
        check("err", err, dn ? '0 : oh);
        check("busy_fall", busy, 0);
        check("ack_post", ack, 0);
        last_m = w;
    endtask

    initial begin
        int fair_exp [6] = '{0, 1, 2, 3, 0, 1};

        rst         = 1'b1;
        req         = '0;
        ctl_tx_done = 1'b0;
        for (int i = 0; i < N; i++) slot[i] = '0;
        load_data();
        repeat (2) @(negedge clk);
        check("rst_pulses", {ack, done, err, ctl_data_valid, busy}, '0);
        check("rst_data", ctl_tx_data, '0);
        check("rst_gid", grant_id, 0);
        rst    = 1'b0;
        last_m = N - 1;

        // Single request with a known payload.
        slot[2] = 128'h0123456789ABCDEF0123456789ABCDEF;
        run_txn(4'b0100, 15, 1'b0, 2);

        // Fairness: all four held, rotation starting at 0.
        run_txn(4'b1000, 10, 1'b0, 3);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) slot[i] = {$urandom, $urandom, $urandom, $urandom};
            run_txn((k == 0) ? 4'b1111 : 4'b0000, 10, 1'b1, fair_exp[k]);
        end
        req = '0;

        // Wrap-around after grant 3.
        run_txn(4'b1000, 4, 1'b0, 3);
        run_txn(4'b1001, 5, 1'b0, 0);
        run_txn(4'b0001, 5, 1'b0, 3);
        req = '0;

        // Timeout, recovery, then tx_done landing on the expiry cycle.
        run_txn(4'b0010, 1000, 1'b0, 1);
        run_txn(4'b0010, 3, 1'b0, 1);
        run_txn(4'b0100, T - 1, 1'b0, 2);

        // Reset while waiting, then a stale tx_done.
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_pulses", {ack, done, err, ctl_data_valid, busy}, '0);
        check("mid_rst_gid", grant_id, 0);
        check("mid_rst_data", ctl_tx_data, '0);
        last_m = N - 1;
        @(negedge clk);
        ctl_tx_done = 1'b1;
        @(negedge clk);
        ctl_tx_done = 1'b0;
        check("stale_a", {done, err, busy}, '0);
        @(negedge clk);
        check("stale_b", {done, err, busy}, '0);
        run_txn(4'b0001, 6, 1'b0, 0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) slot[i] = {$urandom, $urandom, $urandom, $urandom};
            run_txn(N'($urandom_range(0, 15)), int'($urandom_range(0, 26)),
                    ($urandom_range(0, 3) == 0), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares the single 128-bit UART transmit channel of uart_ctl among N_REQ independent requesters.
- Sits between the requesters and uart_ctl's tx_data/data_valid/tx_done interface.
- Captures one 128-bit payload per grant, launches it with a one-cycle data_valid pulse, and waits for tx_done before granting again.
- Reports completion or timeout back to the owning requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 128, payload width per requester; must match uart_ctl tx_data width.
- TIMEOUT_CYCLES, 10000000, clk cycles to wait for ctl_tx_done before abandoning a transfer; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester transfer request; level, held until matching ack.
- req_data  input  N_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- ack  output  N_REQ  one-cycle pulse: payload of requester i captured.
- done  output  N_REQ  one-cycle pulse: requester i transfer completed (ctl_tx_done seen).
- err  output  N_REQ  one-cycle pulse: requester i transfer timed out.
- ctl_tx_data  output  DATA_W  registered payload to uart_ctl tx_data.
- ctl_data_valid  output  1  one-cycle launch pulse to uart_ctl data_valid.
- ctl_tx_done  input  1  completion pulse from uart_ctl tx_done.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  $clog2(N_REQ)  index of current/last granted requester.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. ack, done, err, ctl_data_valid=0. ctl_tx_data=0. grant_id=0. timer=0. Round-robin pointer last=N_REQ-1, so requester 0 has highest priority first.
- Reset mid-transfer forces the same values. A UART frame already in flight downstream is not aborted; any tx_done arriving afterwards is ignored in IDLE.
- All outputs are registered; busy is decoded from the state register.
- FSM states: IDLE, LAUNCH, WAIT.
- IDLE:
  - If any req bit is set, winner = first set bit searching upward from (last+1) mod N_REQ with wrap-around.
  - At that edge: ctl_tx_data <= winner's slice; ack[winner] <= 1 for one cycle; grant_id <= winner; state <= LAUNCH.
  - If no req bit is set, stay in IDLE.
- LAUNCH: ctl_data_valid <= 1 for exactly one cycle; timer <= 0; state <= WAIT.
- WAIT:
  - If ctl_tx_done: done[grant_id] <= 1; last <= grant_id; state <= IDLE.
  - Else if TIMEOUT_CYCLES != 0 and timer == TIMEOUT_CYCLES-1: err[grant_id] <= 1; last <= grant_id; state <= IDLE.
  - Else timer <= timer+1.
  - Timer width is $clog2(TIMEOUT_CYCLES+1); it must not wrap.
- Latency:
  - req sampled high in IDLE at edge k: ack high in cycle k+1, ctl_data_valid high in cycle k+2.
  - ctl_tx_done sampled at edge m: done high in cycle m+1.
  - Earliest next ack: cycle m+2.
- Simultaneous ctl_tx_done and timeout expiry in the same cycle: done wins; err is not asserted.
- ctl_tx_done seen in IDLE or LAUNCH is ignored (stale); no output changes.
- A requester dropping req before ack is legal; it is simply not granted. req is not sampled outside IDLE.
- A requester may reassert req in the cycle after ack. It is served only after every other pending requester has had a turn.
- ack, done and err are one-hot or zero at all times; at most one of the three vectors is non-zero in any cycle.

Test Plan:
- Single request: rst, then req=4'b0100 with data[2]=128'h0123...CDEF. Required: ack=4'b0100 one cycle later; ctl_data_valid one cycle after that with ctl_tx_data=0123...CDEF; grant_id=2. Drive ctl_tx_done 50 cycles later → done=4'b0100 next cycle; busy falls with it.
- Fairness: hold req=4'b1111 and answer each launch with ctl_tx_done after 10 cycles. Required grant order 0,1,2,3,0,1; exactly one ack per transfer.
- Wrap-around: last grant=3, then req=4'b1001 → grant 0. Next with req=4'b1001 → grant 3.
- Timeout: TIMEOUT_CYCLES=20, req=4'b0010, never drive ctl_tx_done. Required: err=4'b0010 exactly 20 cycles after ctl_data_valid; no done; busy=0; next request accepted normally.
- Simultaneous: with TIMEOUT_CYCLES=20, assert ctl_tx_done on the expiry cycle → done pulse only, err stays 0.
- Reset/stale: assert rst while in WAIT → all outputs 0, state IDLE. A ctl_tx_done pulse two cycles later produces no done/err. req=4'b0001 afterwards is granted to requester 0.
